// File: rtl/bp_common_pkg.sv
// bp_common_pkg: shared CLINT address map, FSM state and size encodings.
// Imported by the CLINT top level and its timebase sub-module.
package bp_common_pkg;

    // 4 KiB page holding mipi[c] at c*4
    localparam logic [19:0] clint_mipi_page_gp     = 20'h0_2000;
    // 4 KiB page holding mtimecmp[c] at c*8
    localparam logic [19:0] clint_mtimecmp_page_gp = 20'h0_2004;
    // Doubleword address of the shared mtime counter
    localparam logic [31:0] clint_mtime_addr_gp    = 32'h0200_bff8;

    typedef enum logic {
        e_ready,
        e_resp
    } bp_clint_state_e;

    typedef enum logic [1:0] {
        e_size_1B,
        e_size_2B,
        e_size_4B,
        e_size_8B
    } bp_mem_size_e;

endpackage

// File: rtl/bp_clint_timebase.sv
// bp_clint_timebase: prescaler plus 64-bit mtime counter with half writes.
// Ports: clk_i, reset_n_i, w_lo_i/w_hi_i half write enables, w_data_i, mtime_o.
module bp_clint_timebase
    import bp_common_pkg::*;
#(
    parameter int timebase_div_p = 8
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        w_lo_i,
    input  logic        w_hi_i,
    input  logic [63:0] w_data_i,
    output logic [63:0] mtime_o
);

    localparam int pw_lp =
        (timebase_div_p > 1) ? $clog2(timebase_div_p) : 1;
    localparam logic [pw_lp-1:0] last_lp = pw_lp'(timebase_div_p - 1);

    logic [pw_lp-1:0] presc_q, presc_d;
    logic [63:0]      mtime_q, mtime_d;
    logic             tick;

    always_comb begin
        tick    = (presc_q == last_lp);
        presc_d = tick ? '0 : presc_q + pw_lp'(1);
        mtime_d = mtime_q + 64'(tick);
        // A software write drops this cycle's increment entirely, so the
        // untouched half keeps its pre-increment value.
        if (w_lo_i || w_hi_i) begin
            mtime_d = mtime_q;
            if (w_lo_i) mtime_d[31:0]  = w_data_i[31:0];
            if (w_hi_i) mtime_d[63:32] = w_data_i[63:32];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/bp_clint_controller.sv
// bp_clint_controller: core-local interruptor (mipi, mtimecmp, mtime).
// Ports: cmd_* request in, resp_* response out, per-core sw/timer irqs.
module bp_clint_controller
    import bp_common_pkg::*;
#(
    parameter int num_core_p     = 1,
    parameter int paddr_width_p  = 56,
    parameter int data_width_p   = 64,
    parameter int timebase_div_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     cmd_v_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_w_i,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic [1:0]               cmd_size_i,
    input  logic [data_width_p-1:0]  cmd_data_i,
    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [data_width_p-1:0]  resp_data_o,
    output logic                     resp_err_o,
    output logic [num_core_p-1:0]    software_irq_o,
    output logic [num_core_p-1:0]    timer_irq_o
);

    localparam logic [9:0] ncore_lp = 10'(num_core_p);

    bp_clint_state_e state_q, state_d;
    logic [63:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic [num_core_p-1:0]        mipi_q, mipi_d;
    logic [num_core_p-1:0][63:0]  mtimecmp_q, mtimecmp_d;
    logic [num_core_p-1:0]        timer_irq_q, timer_irq_d;

    logic [63:0] mtime;
    logic        time_w_lo, time_w_hi;

    logic        sz8, size_ok, hi_ok, aligned;
    logic        hit_mipi, hit_cmp, hit_time;
    logic        w_lo, w_hi;
    logic [19:0] page;
    logic [9:0]  mipi_idx, cmp_idx;
    logic [63:0] wdata, sel_cmp, full, rdata;
    logic        sel_mipi;

    bp_clint_timebase #(
        .timebase_div_p(timebase_div_p)
    ) timebase (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .w_lo_i   (time_w_lo),
        .w_hi_i   (time_w_hi),
        .w_data_i (wdata),
        .mtime_o  (mtime)
    );

    // Address decode and read mux
    always_comb begin
        sz8      = (cmd_size_i == e_size_8B);
        size_ok  = (cmd_size_i == e_size_4B) || sz8;
        hi_ok    = (cmd_addr_i[paddr_width_p-1:32] == '0);
        aligned  = sz8 ? (cmd_addr_i[2:0] == 3'b0)
                       : (cmd_addr_i[1:0] == 2'b0);
        page     = cmd_addr_i[31:12];
        mipi_idx = cmd_addr_i[11:2];
        cmp_idx  = {1'b0, cmd_addr_i[11:3]};

        hit_mipi = hi_ok && size_ok && !sz8 && aligned
                && (page == clint_mipi_page_gp)
                && (mipi_idx < ncore_lp);
        hit_cmp  = hi_ok && size_ok && aligned
                && (page == clint_mtimecmp_page_gp)
                && (cmp_idx < ncore_lp);
        hit_time = hi_ok && size_ok && aligned
                && (cmd_addr_i[31:3] == clint_mtime_addr_gp[31:3]);

        w_lo  = sz8 || !cmd_addr_i[2];
        w_hi  = sz8 ||  cmd_addr_i[2];
        // 4B data arrives LSB-aligned; replicate so either half can take it
        wdata = sz8 ? cmd_data_i[63:0]
                    : {cmd_data_i[31:0], cmd_data_i[31:0]};

        sel_cmp  = '0;
        sel_mipi = 1'b0;
        for (int c = 0; c < num_core_p; c++) begin
            if (cmp_idx == 10'(c))  sel_cmp  = mtimecmp_q[c];
            if (mipi_idx == 10'(c)) sel_mipi = mipi_q[c];
        end

        full = hit_time ? mtime : sel_cmp;
        if (hit_mipi)
            rdata = {63'b0, sel_mipi};
        else if (sz8)
            rdata = full;
        else if (cmd_addr_i[2])
            rdata = {32'b0, full[63:32]};
        else
            rdata = {32'b0, full[31:0]};
    end

    // FSM and register updates
    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        mipi_d      = mipi_q;
        mtimecmp_d  = mtimecmp_q;
        time_w_lo   = 1'b0;
        time_w_hi   = 1'b0;

        unique case (state_q)
            e_ready: begin
                if (cmd_v_i) begin
                    state_d     = e_resp;
                    resp_err_d  = !(hit_mipi || hit_cmp || hit_time);
                    resp_data_d = (cmd_w_i || resp_err_d) ? '0 : rdata;
                    if (cmd_w_i) begin
                        for (int c = 0; c < num_core_p; c++) begin
                            if (hit_mipi && mipi_idx == 10'(c))
                                mipi_d[c] = cmd_data_i[0];
                            if (hit_cmp && cmp_idx == 10'(c)) begin
                                if (w_lo) mtimecmp_d[c][31:0]  = wdata[31:0];
                                if (w_hi) mtimecmp_d[c][63:32] = wdata[63:32];
                            end
                        end
                        time_w_lo = hit_time && w_lo;
                        time_w_hi = hit_time && w_hi;
                    end
                end
            end
            e_resp: begin
                if (resp_yumi_i) state_d = e_ready;
            end
            default: state_d = e_ready;
        endcase

        for (int c = 0; c < num_core_p; c++)
            timer_irq_d[c] = (mtime >= mtimecmp_q[c]);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_ready;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            mipi_q      <= '0;
            mtimecmp_q  <= '1;
            timer_irq_q <= '0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            mipi_q      <= mipi_d;
            mtimecmp_q  <= mtimecmp_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    assign cmd_ready_o    = (state_q == e_ready);
    assign resp_v_o       = (state_q == e_resp);
    assign resp_data_o    = resp_data_q;
    assign resp_err_o     = resp_err_q;
    assign software_irq_o = mipi_q;
    assign timer_irq_o    = timer_irq_q;

endmodule

// File: doc/bp_clint_controller.md
Name: bp_clint_controller

Overview:
Memory-mapped core-local interruptor (CLINT) for the 0x02??_???? device window. Holds the per-core machine-software-interrupt (mipi) and mtimecmp registers and the shared mtime counter. Serves one single-beat read/write request at a time from the I/O crossbar. Drives the per-core software and timer interrupt lines into the BE.

Parameters:
num_core_p, 1, number of cores served; supported range 1..16.
paddr_width_p, 56, physical address width (SV39).
data_width_p, 64, request/response data width; fixed at 64.
timebase_div_p, 8, core clocks per mtime increment; at least 1.

Ports:
clk_i  in  1  core clock
reset_n_i  in  1  asynchronous, active-low reset
cmd_v_i  in  1  request valid
cmd_ready_o  out  1  request ready; transfer occurs on v&ready
cmd_w_i  in  1  1 = write, 0 = read
cmd_addr_i  in  paddr_width_p  byte address
cmd_size_i  in  2  log2 of bytes: 2 = 4B, 3 = 8B; 0 and 1 are illegal
cmd_data_i  in  64  write data, LSB-aligned
resp_v_o  out  1  response valid
resp_yumi_i  in  1  response consumed
resp_data_o  out  64  read data, zero-extended
resp_err_o  out  1  access fault
software_irq_o  out  num_core_p  mipi[c] bit 0
timer_irq_o  out  num_core_p  registered (mtime >= mtimecmp[c])

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_n_i. Reset values: state e_ready, cmd_ready_o=1, resp_v_o=0, resp_data_o=0, resp_err_o=0, mtime=0, prescaler=0, every mtimecmp=all ones, every mipi=0, software_irq_o=0, timer_irq_o=0.
- FSM has two states.
  - e_ready: cmd_ready_o=1. On cmd_v_i, decode and perform the access at that clock edge, then load resp_* and move to e_resp.
  - e_resp: resp_v_o=1, cmd_ready_o=0. resp_data_o and resp_err_o are held stable. On resp_yumi_i, return to e_ready.
  - Latency is 1 cycle from accept to resp_v_o. Throughput is one request per 2 cycles. Only one request is outstanding.
- Decode requires addr bits [paddr_width_p-1:32] = 0.
  - mipi[c]: addr[31:12]=0x02000, c = addr[11:2]. Size 4 only. Only bit 0 is writable; reads return {63'b0, bit0}.
  - mtimecmp[c]: addr[31:12]=0x02004, c = addr[11:3]. Size 8 must be 8B-aligned. Size 4 writes or reads the half selected by addr[2]; the other half is unchanged.
  - mtime: addr[31:3] = 0x0200_bff8>>3. Same size and half rules as mtimecmp.
- Error cases: core index >= num_core_p, any unmapped offset, misalignment, size 0/1, or size 8 to mipi. These give resp_err_o=1, resp_data_o=0, and no state change.
- mtime timebase:
  - The prescaler counts 0..timebase_div_p-1.
  - mtime increments by 1 in the cycle the prescaler equals timebase_div_p-1; the prescaler then returns to 0.
  - mtime wraps from 2^64-1 to 0.
  - A write to mtime in the same cycle as an increment: the written value wins and the increment is dropped. The prescaler is not reset by the write.
- Timer interrupt: timer_irq_o[c] is registered from the current mtime and mtimecmp[c] using an unsigned compare. A register write at edge T is visible on the irq at edge T+1. A half write to mtimecmp is compared as the merged 64-bit value.
- software_irq_o[c] is the mipi[c] flop directly; a write appears in the cycle after the accept edge.
- Async reset in e_resp drops the pending response. No response is generated after reset.
- cmd_* inputs are ignored when cmd_ready_o=0.

Decomposition:
- Package (bp_common_pkg):
  - The mipi, mtimecmp and mtime address constants.
  - A bp_clint_state_e typedef {e_ready, e_resp}.
  - A bp_mem_size_e enum {e_size_1B, e_size_2B, e_size_4B, e_size_8B}.
- Sub-module bp_clint_timebase: prescaler and 64-bit mtime counter, with write-enable/half-select inputs and the write-over-increment priority. The top level holds the decode, FSM, registers and irq compare.

Test Plan:
- Reset, then read mtime (addr 0x0200_bff8, size 3) before the first tick -> resp_v_o 1 cycle after accept, data 0, err 0. Also check software_irq_o=0, timer_irq_o=0, mtimecmp[0] reads 0xFFFF_FFFF_FFFF_FFFF.
- div=4: write mtimecmp[0]=10, then idle -> timer_irq_o[0] rises on the first edge after mtime reaches 10 (about 40 cycles). Then write mtimecmp[0]=0xFFFF_FFFF_FFFF_FFFF -> irq drops the next cycle.
- num_core_p=2: write 1 to mipi at 0x0200_0004 -> software_irq_o=2'b10. Read back 1. Write 0 -> 2'b00.
- Error accesses, each -> err=1, data 0, registers unchanged:
  - read 0x0200_0008 with num_core_p=2;
  - size-3 write to 0x0200_0000;
  - read 0x0200_4004 with size 3;
  - size-1 write;
  - 0x0300_0000.
- Hold resp_yumi_i=0 for 5 cycles -> resp_v_o stays 1 with data stable and cmd_ready_o=0. A cmd_v_i pulse during the hold is ignored.
- Size-4 write 0x1 to the high half of mtime (0x0200_bffc) on a tick cycle -> mtime = 0x1_xxxx_xxxx with the low half unincremented. Also assert reset_n_i low in e_resp -> resp_v_o=0 immediately and mtime=0.
